pc_n2t: RTL and testbench
=========================

PC_N2T -- requirements
Module: pc_n2t

Interface
REQ-001 SHALL have parameter WIDTH, default 16, giving the counter width in bits.
REQ-002 SHALL have parameter RESET_VEC, default 0, giving the value loaded by async reset and by clr.
REQ-003 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset, input, 1; reset is asynchronous and active-low (0 = reset asserted).
REQ-005 SHALL have port in, input, WIDTH, the jump target.
REQ-006 SHALL have port load, input, 1; when high, out takes in at the next edge.
REQ-007 SHALL have port inc, input, 1; when high, out increments by 1 at the next edge.
REQ-008 SHALL have port clr, input, 1; synchronous clear to RESET_VEC.
REQ-009 SHALL have port out, output, WIDTH, the current counter value, driven directly from the register.
REQ-010 SHALL have port wrap, output, 1; sticky wrap flag, present only when PC_WRAP_FLAG_EN is defined.

Function
REQ-011 SHALL apply per-edge priority clr > load > inc > hold.
REQ-012 SHALL set out to RESET_VEC on the edge after clr=1, regardless of load or inc.
REQ-013 SHALL set out to in on the edge after load=1 and clr=0, regardless of inc.
REQ-014 SHALL set out to out+1 modulo 2^WIDTH on the edge after inc=1, load=0 and clr=0.
REQ-015 SHALL hold out when clr, load and inc are all 0.
REQ-016 SHALL apply a one-edge latency from any control input to out, with no combinational path from inputs to out.
REQ-017 SHALL wrap at the top value: out=2^WIDTH-1 with inc only gives out=0 on the next edge.
REQ-018 SHALL have a two-state FSM, RUN and WRAPPED, when PC_WRAP_FLAG_EN is defined.
REQ-019 SHALL move from RUN to WRAPPED on the edge where REQ-017 occurs.
REQ-020 SHALL move from WRAPPED to RUN on clr, and only on clr; load does not clear the flag.
REQ-021 SHALL drive wrap=1 exactly when the FSM is in WRAPPED.
REQ-022 SHALL treat simultaneous clr and a wrap condition as clr: out=RESET_VEC, FSM in RUN.

Reset
REQ-023 SHALL force out=RESET_VEC and the FSM to RUN (wrap=0) immediately when reset goes to 0, independent of clk.
REQ-024 SHALL ignore clr, load and inc while reset=0.
REQ-025 SHALL resume normal operation from the first rising clk edge after reset returns to 1.
REQ-026 SHALL abandon any operation in flight when reset is asserted mid-operation; no pending load or inc survives.

Configuration
REQ-027 SHALL compile the wrap port, the FSM and the flag logic in only when macro PC_WRAP_FLAG_EN is defined.
REQ-028 SHALL, without PC_WRAP_FLAG_EN, have no wrap port; counting and wrap-around of out are unchanged.

Structure
REQ-029 SHALL take the default WIDTH, the default RESET_VEC and the FSM state enum (RUN, WRAPPED) from shared package pc_n2t_pkg.
REQ-030 SHALL hold out in one sub-module, register_n2t: a WIDTH-bit load-enabled register built from bit_n2t cells, with an async active-low reset value port.
REQ-031 SHALL keep the next-value mux and incrementer in pc_n2t, feeding register_n2t with load tied high on any state change.

Verification
REQ-032 SHALL check reset and increment: reset=0 with in=16'h1234 and load=1 -> out=0 with no clk edge; release reset, inc=1 for 3 edges -> out=3.
REQ-033 SHALL check priority: out=3, clr=1, load=1, in=16'h00FF, inc=1, one edge -> out=0; then clr=0, same inputs, one edge -> out=16'h00FF.
REQ-034 SHALL check hold: out=16'h00FF with all controls 0 for 4 edges -> out=16'h00FF each edge.
REQ-035 SHALL check wrap: load in=16'hFFFE, then inc for 2 edges -> out=16'hFFFF, then 16'h0000; with PC_WRAP_FLAG_EN, wrap=1 after the second edge.
REQ-036 SHALL check flag stickiness: after REQ-035, load in=16'h0010 -> wrap stays 1; clr -> out=0, wrap=0.
REQ-037 SHALL check reset mid-operation: inc=1 at out=5, assert reset between edges -> out=0 at once, wrap=0; release -> next edge out=1.

Source files
------------

// File: rtl/pc_n2t_pkg.sv
// Shared defaults and wrap-flag FSM state type for the pc_n2t program counter.
package pc_n2t_pkg;

  localparam int unsigned PC_WIDTH_DEF     = 16;
  localparam int unsigned PC_RESET_VEC_DEF = 0;

  typedef enum logic {
    RUN     = 1'b0,
    WRAPPED = 1'b1
  } pc_state_e;

endpackage

// File: rtl/bit_n2t.sv
// Single load-enabled storage bit with an async active-low reset to a supplied value.
module bit_n2t (
  input  logic clk,
  input  logic rst_n,
  input  logic i_rst_val,
  input  logic i_d,
  input  logic i_load,
  output logic o_q
);

  logic r_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      r_q <= i_rst_val;
    else if (i_load) r_q <= i_d;
  end

  assign o_q = r_q;

endmodule

// File: rtl/register_n2t.sv
// WIDTH-bit load-enabled register assembled from bit_n2t cells.
module register_n2t
  import pc_n2t_pkg::*;
#(
  parameter int unsigned WIDTH = PC_WIDTH_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] i_rst_val,
  input  logic [WIDTH-1:0] i_d,
  input  logic             i_load,
  output logic [WIDTH-1:0] o_q
);

  for (genvar g = 0; g < WIDTH; g++) begin : g_bit
    bit_n2t u_bit (
      .clk       (clk),
      .rst_n     (rst_n),
      .i_rst_val (i_rst_val[g]),
      .i_d       (i_d[g]),
      .i_load    (i_load),
      .o_q       (o_q[g])
    );
  end

endmodule

// File: rtl/pc_n2t.sv
// Program counter with clr > load > inc > hold priority; define PC_WRAP_FLAG_EN for the sticky wrap flag.
module pc_n2t
  import pc_n2t_pkg::*;
#(
  parameter int unsigned WIDTH     = PC_WIDTH_DEF,
  parameter int unsigned RESET_VEC = PC_RESET_VEC_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] in,
  input  logic             load,
  input  logic             inc,
  input  logic             clr,
  output logic [WIDTH-1:0] out
`ifdef PC_WRAP_FLAG_EN
  ,
  output logic             wrap
`endif
);

  localparam logic [WIDTH-1:0] RST_VAL = WIDTH'(RESET_VEC);

  logic [WIDTH-1:0] w_next;
  logic [WIDTH-1:0] w_incr;
  logic             w_reg_load;

  assign w_incr     = out + WIDTH'(1);
  assign w_reg_load = clr | load | inc;

  always_comb begin
    w_next = out;
    if (clr)       w_next = RST_VAL;
    else if (load) w_next = in;
    else if (inc)  w_next = w_incr;
  end

  register_n2t #(
    .WIDTH (WIDTH)
  ) u_reg (
    .clk       (clk),
    .rst_n     (reset),
    .i_rst_val (RST_VAL),
    .i_d       (w_next),
    .i_load    (w_reg_load),
    .o_q       (out)
  );

`ifdef PC_WRAP_FLAG_EN
  pc_state_e r_state;
  logic      r_wrap;
  logic      w_wrap_evt;

  // only a plain increment off the all-ones value counts as a wrap
  assign w_wrap_evt = inc & ~load & ~clr & (&out);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= RUN;
      r_wrap  <= 1'b0;
    end else begin
      case (r_state)
        RUN: begin
          if (w_wrap_evt) begin
            r_state <= WRAPPED;
            r_wrap  <= 1'b1;
          end
        end
        WRAPPED: begin
          if (clr) begin
            r_state <= RUN;
            r_wrap  <= 1'b0;
          end
        end
        default: begin
          r_state <= RUN;
          r_wrap  <= 1'b0;
        end
      endcase
    end
  end

  assign wrap = r_wrap;
`endif

endmodule

// File: tb/tb_pc_n2t.sv
// Self-checking bench for pc_n2t: directed scenarios then randomized traffic against a behavioural model.
module tb_pc_n2t;

  logic        clk;
  logic        reset;
  logic [15:0] in;
  logic        load;
  logic        inc;
  logic        clr;
  logic [15:0] out;
`ifdef PC_WRAP_FLAG_EN
  logic        wrap;
`endif

  int n_cmp = 0;
  int n_mis = 0;

  int m_pc   = 0;
  bit m_wrap = 0;

  pc_n2t #(.WIDTH(16), .RESET_VEC(0)) dut (
    .clk   (clk),
    .reset (reset),
    .in    (in),
    .load  (load),
    .inc   (inc),
    .clr   (clr),
    .out   (out)
`ifdef PC_WRAP_FLAG_EN
    ,
    .wrap  (wrap)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk_out(input string tag, input logic [15:0] exp);
    n_cmp++;
    assert (out === exp) else begin
      n_mis++;
      $error("FAIL %s out observed=%h expected=%h", tag, out, exp);
    end
  endtask

  task automatic chk_wrap(input string tag, input logic exp);
`ifdef PC_WRAP_FLAG_EN
    n_cmp++;
    assert (wrap === exp) else begin
      n_mis++;
      $error("FAIL %s wrap observed=%b expected=%b", tag, wrap, exp);
    end
`endif
  endtask

  // Reference behaviour for one rising edge, from the current inputs.
  task automatic model_edge();
    if (clr) begin
      m_pc   = 0;
      m_wrap = 0;
    end else if (load) begin
      m_pc = int'(in);
    end else if (inc) begin
      if (m_pc == 65535) begin
        m_pc   = 0;
        m_wrap = 1;
      end else begin
        m_pc = m_pc + 1;
      end
    end
  endtask

  task automatic model_reset();
    m_pc   = 0;
    m_wrap = 0;
  endtask

  task automatic step(input string tag);
    @(posedge clk);
    if (reset) model_edge();
    #1;
    chk_out(tag, 16'(m_pc));
    chk_wrap(tag, m_wrap);
  endtask

  initial begin
    reset = 1'b1; in = '0; load = 0; inc = 0; clr = 0;

    // reset asserted with load pending: out must clear without a clock edge
    #1;
    reset = 1'b0; in = 16'h1234; load = 1'b1;
    model_reset();
    #1;
    chk_out("rst_async", 16'h0000);
    chk_wrap("rst_async", 1'b0);
    #1;
    load = 1'b0; inc = 1'b1; reset = 1'b1;
    step("inc1");
    step("inc2");
    step("inc3");
    chk_out("inc3_lit", 16'h0003);

    // priority
    clr = 1'b1; load = 1'b1; in = 16'h00FF; inc = 1'b1;
    step("prio_clr");
    chk_out("prio_clr_lit", 16'h0000);
    clr = 1'b0;
    step("prio_load");
    chk_out("prio_load_lit", 16'h00FF);

    // hold
    load = 1'b0; inc = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step("hold");
      chk_out("hold_lit", 16'h00FF);
    end

    // wrap
    load = 1'b1; in = 16'hFFFE;
    step("wrap_load");
    load = 1'b0; inc = 1'b1;
    step("wrap_ffff");
    chk_out("wrap_ffff_lit", 16'hFFFF);
    chk_wrap("wrap_pre", 1'b0);
    step("wrap_0000");
    chk_out("wrap_0000_lit", 16'h0000);
    chk_wrap("wrap_set", 1'b1);

    // stickiness
    inc = 1'b0; load = 1'b1; in = 16'h0010;
    step("sticky_load");
    chk_wrap("sticky_keep", 1'b1);
    load = 1'b0; clr = 1'b1;
    step("sticky_clr");
    chk_wrap("sticky_clr_lit", 1'b0);
    clr = 1'b0;

    // clr coinciding with a wrap condition
    load = 1'b1; in = 16'hFFFF;
    step("clrwrap_load");
    load = 1'b0; inc = 1'b1; clr = 1'b1;
    step("clrwrap");
    chk_out("clrwrap_lit", 16'h0000);
    chk_wrap("clrwrap_lit", 1'b0);
    clr = 1'b0; inc = 1'b0;

    // reset mid-operation
    load = 1'b1; in = 16'h0005;
    step("mid_load5");
    load = 1'b0; inc = 1'b1;
    #2;
    reset = 1'b0;
    model_reset();
    #1;
    chk_out("mid_rst", 16'h0000);
    chk_wrap("mid_rst", 1'b0);
    #2;
    reset = 1'b1;
    step("mid_resume");
    chk_out("mid_resume_lit", 16'h0001);

    // randomized traffic, biased towards the top of the range to exercise wrap
    for (int i = 0; i < 400; i++) begin
      clr  = ($urandom_range(0, 15) == 0);
      load = ($urandom_range(0, 7) == 0);
      inc  = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 2) == 0) in = 16'hFFF0 | 16'($urandom_range(0, 15));
      else                           in = 16'($urandom);
      if ($urandom_range(0, 49) == 0) begin
        #2;
        reset = 1'b0;
        model_reset();
        #1;
        chk_out("rnd_rst", 16'h0000);
        chk_wrap("rnd_rst", 1'b0);
        #1;
        reset = 1'b1;
      end
      step("rnd");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
